// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM states, default
// geometry and the round-robin pick rule.
package ram_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // A lone requester wins; on contention the one not served last wins.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    logic pick;
    if (v0 && !v1) begin
      pick = 1'b0;
    end else if (v1 && !v0) begin
      pick = 1'b1;
    end else begin
      pick = ~last;
    end
    return pick;
  endfunction

endpackage

// File: rtl/sync_ram.sv
// Single-port synchronous RAM, read latency 1, read-before-write.
// Contents are deliberately not reset.
module sync_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_r [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] dout_r;

  // Storage array and registered read port.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_r[addr] <= din;
      end
      dout_r <= mem_r[addr];
    end
  end

  assign dout = dout_r;

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester round-robin front end for a sync_ram, with a zero-clear
// sweep after reset and on clr_req.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  init_done,
  input  logic                  r0_valid,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_ready,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_valid,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_ready,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  state_e                state_r, state_s;
  logic [ADDR_WIDTH-1:0] cnt_r, cnt_s;
  logic                  last_r;
  logic                  init_done_r;
  logic                  rvalid0_r, rvalid1_r;
  logic                  grant_s, accept_s;
  logic                  ready0_s, ready1_s;
  logic                  xfer0_s, xfer1_s;
  logic                  ram_en_s, ram_we_s;
  logic [ADDR_WIDTH-1:0] ram_addr_s;
  logic [DATA_WIDTH-1:0] ram_din_s;
  logic [DATA_WIDTH-1:0] ram_dout_s;

  // State and clear-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      cnt_r       <= ADDR_ZERO;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      init_done_r <= (state_s == ST_RUN);
    end
  end

  // Next state: sweep every address once, then serve until a clear request.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_INIT: begin
        cnt_s = cnt_r + ADDR_ONE;
        if (cnt_r == LAST_ADDR) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_RUN: begin
        if (clr_req) begin
          state_s = ST_INIT;
          cnt_s   = ADDR_ZERO;
        end else begin
          state_s = ST_RUN;
          cnt_s   = cnt_r;
        end
      end
      default: begin
        state_s = ST_INIT;
        cnt_s   = ADDR_ZERO;
      end
    endcase
  end

  // Grant decode; ready is withheld in the clr_req cycle itself.
  always_comb begin
    grant_s  = rr_pick(r0_valid, r1_valid, last_r);
    accept_s = (state_r == ST_RUN) && !clr_req;
    ready0_s = accept_s && !grant_s;
    ready1_s = accept_s && grant_s;
    xfer0_s  = r0_valid && ready0_s;
    xfer1_s  = r1_valid && ready1_s;
  end

  // RAM port mux: the sweep owns the RAM in INIT, else the granted transfer.
  always_comb begin
    ram_en_s   = 1'b0;
    ram_we_s   = 1'b0;
    ram_addr_s = ADDR_ZERO;
    ram_din_s  = DATA_ZERO;
    if (state_r == ST_INIT) begin
      ram_en_s   = 1'b1;
      ram_we_s   = 1'b1;
      ram_addr_s = cnt_r;
      ram_din_s  = DATA_ZERO;
    end else if (xfer1_s) begin
      ram_en_s   = 1'b1;
      ram_we_s   = r1_we;
      ram_addr_s = r1_addr;
      ram_din_s  = r1_wdata;
    end else if (xfer0_s) begin
      ram_en_s   = 1'b1;
      ram_we_s   = r0_we;
      ram_addr_s = r0_addr;
      ram_din_s  = r0_wdata;
    end else begin
      ram_en_s   = 1'b0;
      ram_we_s   = 1'b0;
      ram_addr_s = ADDR_ZERO;
      ram_din_s  = DATA_ZERO;
    end
  end

  // Last-grant and read-response strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r    <= 1'b1;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
    end else begin
      if (xfer1_s) begin
        last_r <= 1'b1;
      end else if (xfer0_s) begin
        last_r <= 1'b0;
      end
      rvalid0_r <= xfer0_s && !r0_we;
      rvalid1_r <= xfer1_s && !r1_we;
    end
  end

  sync_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en_s),
    .we   (ram_we_s),
    .addr (ram_addr_s),
    .din  (ram_din_s),
    .dout (ram_dout_s)
  );

  assign init_done = init_done_r;
  assign r0_ready  = ready0_s;
  assign r1_ready  = ready1_s;
  assign r0_rvalid = rvalid0_r;
  assign r1_rvalid = rvalid1_r;
  assign r0_rdata  = rvalid0_r ? ram_dout_s : DATA_ZERO;
  assign r1_rdata  = rvalid1_r ? ram_dout_s : DATA_ZERO;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, corner-case
// sequences and constrained-random traffic against a behavioural model.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_req = 1'b0;
  logic       init_done;
  logic       v0 = 1'b0, we0 = 1'b0, v1 = 1'b0, we1 = 1'b0;
  logic [3:0] a0 = 4'd0, a1 = 4'd0;
  logic [7:0] d0 = 8'd0, d1 = 8'd0;
  logic       r0_ready, r0_rvalid, r1_ready, r1_rvalid;
  logic [7:0] r0_rdata, r1_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  logic [7:0] m_mem [16];
  bit         m_run;
  bit         m_last;
  int         m_cnt;
  bit         m_pv0, m_pv1;
  logic [7:0] m_pd0, m_pd1;
  bit         e_rdy0, e_rdy1;

  // actuals captured at the last sample point
  logic       g_done, g_rdy0, g_rdy1, g_rv0, g_rv1;
  logic [7:0] g_rd0, g_rd1;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .init_done(init_done),
    .r0_valid(v0), .r0_we(we0), .r0_addr(a0), .r0_wdata(d0),
    .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(v1), .r1_we(we1), .r1_addr(a1), .r1_wdata(d1),
    .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_cnt  = 0;
    m_last = 1'b1;
    m_pv0  = 1'b0;
    m_pv1  = 1'b0;
  endtask

  // One clock: sample and compare at negedge, advance model at posedge.
  task automatic cycle();
    bit g;
    bit x0, x1;
    @(negedge clk);
    if (v0 && !v1)      g = 1'b0;
    else if (v1 && !v0) g = 1'b1;
    else                g = !m_last;
    e_rdy0 = m_run && !clr_req && !g;
    e_rdy1 = m_run && !clr_req && g;
    g_done = init_done; g_rdy0 = r0_ready; g_rdy1 = r1_ready;
    g_rv0 = r0_rvalid;  g_rv1 = r1_rvalid; g_rd0 = r0_rdata; g_rd1 = r1_rdata;
    chk("init_done", 32'(init_done), 32'(m_run));
    chk("r0_ready",  32'(r0_ready),  32'(e_rdy0));
    chk("r1_ready",  32'(r1_ready),  32'(e_rdy1));
    chk("r0_rvalid", 32'(r0_rvalid), 32'(m_pv0));
    chk("r1_rvalid", 32'(r1_rvalid), 32'(m_pv1));
    chk("r0_rdata",  32'(r0_rdata),  m_pv0 ? 32'(m_pd0) : 32'd0);
    chk("r1_rdata",  32'(r1_rdata),  m_pv1 ? 32'(m_pd1) : 32'd0);
    @(posedge clk);
    x0 = v0 && e_rdy0;
    x1 = v1 && e_rdy1;
    m_pv0 = x0 && !we0;
    m_pv1 = x1 && !we1;
    if (m_pv0) m_pd0 = m_mem[a0];
    if (m_pv1) m_pd1 = m_mem[a1];
    if (x0 && we0) m_mem[a0] = d0;
    if (x1 && we1) m_mem[a1] = d1;
    if (x0) m_last = 1'b0;
    if (x1) m_last = 1'b1;
    if (!m_run) begin
      m_mem[m_cnt] = 8'h00;
      if (m_cnt == 15) begin
        m_run = 1'b1;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else if (clr_req) begin
      m_run = 1'b0;
      m_cnt = 0;
    end
    #1;
  endtask

  task automatic idle();
    v0 = 1'b0; v1 = 1'b0; we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
  endtask

  // Counts cycles with init_done low until it rises (bounded).
  task automatic wait_init(input string nm);
    int n;
    n = 0;
    cycle();
    while (!g_done && n < 64) begin
      n++;
      cycle();
    end
    chk(nm, 32'(n), 32'd16);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_done"},   32'(init_done), 32'd0);
    chk({nm, "_ready0"}, 32'(r0_ready),  32'd0);
    chk({nm, "_ready1"}, 32'(r1_ready),  32'd0);
    chk({nm, "_rv0"},    32'(r0_rvalid), 32'd0);
    chk({nm, "_rv1"},    32'(r1_rvalid), 32'd0);
    chk({nm, "_rd0"},    32'(r0_rdata),  32'd0);
    chk({nm, "_rd1"},    32'(r1_rdata),  32'd0);
  endtask

  typedef struct {
    logic v0, we0; logic [3:0] a0; logic [7:0] d0;
    logic v1, we1; logic [3:0] a1; logic [7:0] d1;
    logic rdy0, rdy1, rv0, rv1; logic [7:0] rd0, rd1;
  } vec_t;

  vec_t tbl [9];

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    model_reset();
    tbl[0] = '{1'b1,1'b1,4'd3,8'hA5, 1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h00,8'h00};
    tbl[1] = '{1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,4'd3,8'h00, 1'b0,1'b1,1'b0,1'b0,8'h00,8'h00};
    tbl[2] = '{1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,1'b0,1'b1,8'h00,8'hA5};
    tbl[3] = '{1'b1,1'b1,4'd5,8'h11, 1'b1,1'b1,4'd6,8'h22, 1'b1,1'b0,1'b0,1'b0,8'h00,8'h00};
    tbl[4] = '{1'b1,1'b1,4'd5,8'h33, 1'b1,1'b1,4'd6,8'h22, 1'b0,1'b1,1'b0,1'b0,8'h00,8'h00};
    tbl[5] = '{1'b1,1'b1,4'd5,8'h33, 1'b1,1'b0,4'd5,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h00,8'h00};
    tbl[6] = '{1'b1,1'b0,4'd6,8'h00, 1'b1,1'b0,4'd5,8'h00, 1'b0,1'b1,1'b0,1'b0,8'h00,8'h00};
    tbl[7] = '{1'b1,1'b0,4'd6,8'h00, 1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,1'b0,1'b1,8'h00,8'h33};
    tbl[8] = '{1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,4'd0,8'h00, 1'b0,1'b1,1'b1,1'b0,8'h22,8'h00};

    // reset state, then first sweep of 16 cycles
    #2;
    check_reset_outputs("rst0");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init("init_len_after_reset");

    // directed table: write/read-after, round-robin r0,r1,r0,r1
    for (int i = 0; i < 9; i++) begin
      v0 = tbl[i].v0; we0 = tbl[i].we0; a0 = tbl[i].a0; d0 = tbl[i].d0;
      v1 = tbl[i].v1; we1 = tbl[i].we1; a1 = tbl[i].a1; d1 = tbl[i].d1;
      cycle();
      chk($sformatf("tbl%0d_ready0", i), 32'(g_rdy0), 32'(tbl[i].rdy0));
      chk($sformatf("tbl%0d_ready1", i), 32'(g_rdy1), 32'(tbl[i].rdy1));
      chk($sformatf("tbl%0d_rv0", i),    32'(g_rv0),  32'(tbl[i].rv0));
      chk($sformatf("tbl%0d_rv1", i),    32'(g_rv1),  32'(tbl[i].rv1));
      chk($sformatf("tbl%0d_rd0", i),    32'(g_rd0),  32'(tbl[i].rd0));
      chk($sformatf("tbl%0d_rd1", i),    32'(g_rd1),  32'(tbl[i].rd1));
    end
    idle();

    // clear request: pending read still delivered, ready low, 16-cycle sweep
    v0 = 1'b1; we0 = 1'b1; a0 = 4'd7; d0 = 8'h3C;
    cycle();
    we0 = 1'b0;
    cycle();
    clr_req = 1'b1;
    cycle();
    chk("clr_ready0", 32'(g_rdy0), 32'd0);
    chk("clr_rv0", 32'(g_rv0), 32'd1);
    chk("clr_rd0", 32'(g_rd0), 32'h3C);
    clr_req = 1'b0;
    wait_init("init_len_after_clr");
    v0 = 1'b0;
    cycle();
    chk("after_clr_rv0", 32'(g_rv0), 32'd1);
    chk("after_clr_rd0_addr7", 32'(g_rd0), 32'h00);

    // reset during an r1 read response
    v1 = 1'b1; we1 = 1'b0; a1 = 4'd3;
    cycle();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_read");
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle();
    rst_n = 1'b1;
    wait_init("init_len_after_midreset");

    // all addresses read back zero after a sweep
    for (int i = 0; i < 17; i++) begin
      v0 = (i < 16); a0 = 4'(i);
      cycle();
      if (i > 0) begin
        chk("readall_rv0", 32'(g_rv0), 32'd1);
        chk("readall_rd0", 32'(g_rd0), 32'd0);
      end
    end
    idle();

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      if (!(v0 && !e_rdy0) || i == 0) begin
        v0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
        a0 = 4'($urandom); d0 = 8'($urandom);
      end
      if (!(v1 && !e_rdy1) || i == 0) begin
        v1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
        a1 = 4'($urandom); d1 = 8'($urandom);
      end
      clr_req = ($urandom_range(0, 59) == 0);
      cycle();
    end
    idle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, SHALL be the RAM address width; depth = 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL be the RAM data width.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 clr_req  in  1  SHALL request a full zero-clear of the RAM.
REQ-006 init_done  out  1  SHALL be high when the RAM is cleared and requests are served.
REQ-007 r0_valid  in  1  SHALL indicate a requester-0 access request.
REQ-008 r0_we  in  1  SHALL select write (1) or read (0).
REQ-009 r0_addr  in  ADDR_WIDTH  SHALL be the access address.
REQ-010 r0_wdata  in  DATA_WIDTH  SHALL be the write data.
REQ-011 r0_ready  out  1  SHALL be the grant; a transfer occurs when r0_valid and r0_ready are both high.
REQ-012 r0_rvalid  out  1  SHALL be the one-cycle read-response strobe.
REQ-013 r0_rdata  out  DATA_WIDTH  SHALL be the read data; it is 0 whenever r0_rvalid is low.
REQ-014 r1_valid, r1_we, r1_addr, r1_wdata, r1_ready, r1_rvalid, r1_rdata SHALL mirror the r0_* ports for requester 1.

Function
REQ-015 The control FSM SHALL have two states: INIT and RUN.
REQ-016 In INIT, each cycle SHALL write 0 to the address held by the clear counter, then increment the counter.
REQ-017 After address 2**ADDR_WIDTH-1 is written, the FSM SHALL enter RUN; init_done rises that edge, giving 16 INIT cycles at defaults.
REQ-018 clr_req high in RUN SHALL send the FSM to INIT next edge: counter to 0, init_done low.
REQ-019 clr_req SHALL be ignored in INIT; it neither restarts nor extends the sweep.
REQ-020 rN_ready SHALL equal (state==RUN) and not clr_req and (grant==N), combinationally.
REQ-021 Arbitration SHALL be round-robin with a last-grant register.
- If only one requester is valid, it is granted.
- If both are valid, the requester not last granted is granted.
- The last-grant register updates only on a completed transfer.
REQ-022 Throughput SHALL be one transfer per cycle; the RAM is accessed only by the granted transfer or by the INIT sweep.
REQ-023 A write transfer SHALL update the RAM at that edge and produce no response.
REQ-024 A read transfer at edge t SHALL assert rN_rvalid for exactly the cycle after t, with rN_rdata equal to the RAM content at t.
REQ-025 A read issued the cycle after a write to the same address SHALL return the newly written data.
REQ-026 A read response pending when clr_req is accepted SHALL still be delivered, in the clr_req cycle.
REQ-027 Requesters hold valid and fields stable until ready; a request dropped before its transfer SHALL have no effect.

Reset
REQ-028 While rst_n is low, these SHALL hold immediately, independent of clk:
- state=INIT, clear counter=0, last-grant=requester 1 (so requester 0 wins first)
- init_done=0, r0_ready=r1_ready=0, r0_rvalid=r1_rvalid=0, r0_rdata=r1_rdata=0
REQ-029 Reset asserted mid-sweep or mid-read SHALL abort the operation; no rvalid is produced for a read in flight; the sweep restarts at address 0 after release.
REQ-030 RAM contents SHALL NOT be reset by rst_n; they are cleared only by the INIT sweep.

Structure
REQ-031 Package ram_arb_pkg SHALL hold the FSM state enum (ST_INIT, ST_RUN) and the default ADDR_WIDTH/DATA_WIDTH constants.
REQ-032 The storage SHALL be one instance of sync_ram (write-enable, address, write data, registered read data; read latency 1); the arbiter muxes its we/addr/din.

Verification
REQ-033 Reset release, no requests -> init_done low for 16 cycles, then high; all addresses read back 0x00.
REQ-034 r0 writes 0xA5 to address 3; next cycle r1 reads address 3 -> r1_rvalid one cycle later with r1_rdata=0xA5, r0_rvalid stays 0.
REQ-035 r0 and r1 both valid for 4 cycles after init -> grants in order r0, r1, r0, r1.
REQ-036 clr_req in RUN after writing 0x3C to address 7 -> ready low that cycle, init_done low for 16 cycles, address 7 then reads 0x00.
REQ-037 rst_n pulsed low the cycle after an r1 read transfer -> no r1_rvalid, all outputs 0, INIT sweep restarts.
